// File: rtl/pifo_sched_ctrl.sv
// pifo_sched_ctrl: buffers enqueue/dequeue requests and arbitrates them onto a PIFO insert/remove port (optional macro PIFO_SCHED_DROP_EN drops enqueues while full)
module pifo_sched_ctrl #(
  parameter int RANK_WIDTH    = 10,
  parameter int META_WIDTH    = 20,
  parameter int L2_MAX_SIZE   = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [RANK_WIDTH-1:0] enq_rank,
  input  logic [META_WIDTH-1:0] enq_meta,
  input  logic                  deq_req,
  output logic                  deq_ready,
  output logic                  deq_valid,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic                  deq_miss,
  output logic                  pifo_insert,
  output logic                  pifo_remove,
  output logic [RANK_WIDTH-1:0] pifo_rank_in,
  output logic [META_WIDTH-1:0] pifo_meta_in,
  input  logic [RANK_WIDTH-1:0] pifo_rank_out,
  input  logic [META_WIDTH-1:0] pifo_meta_out,
  input  logic                  pifo_valid_out,
  input  logic                  pifo_busy,
  input  logic                  pifo_full,
  output logic [L2_MAX_SIZE:0]  occupancy,
  output logic [15:0]           drop_count
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;
  localparam logic GR_INS = 1'b0;
  localparam logic GR_REM = 1'b1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [L2_MAX_SIZE:0] OCC_ONE = (L2_MAX_SIZE+1)'(1);
  localparam logic [L2_MAX_SIZE:0] OCC_MAX = {1'b1, {L2_MAX_SIZE{1'b0}}};

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  enq_buf_valid_q, enq_buf_valid_d;
  logic [RANK_WIDTH-1:0] enq_rank_q, enq_rank_d;
  logic [META_WIDTH-1:0] enq_meta_q, enq_meta_d;
  logic                  deq_pend_q, deq_pend_d;
  logic                  last_grant_q, last_grant_d;
  logic [L2_MAX_SIZE:0]  occ_q, occ_d;
  logic                  deq_valid_q, deq_valid_d;
  logic [RANK_WIDTH-1:0] deq_rank_q, deq_rank_d;
  logic [META_WIDTH-1:0] deq_meta_q, deq_meta_d;
  logic                  deq_miss_q, deq_miss_d;
  logic idle, ins_ok, rem_ok, grant_ins, grant_rem, miss, drop, enq_acc, deq_acc;

  assign idle      = state_q == IDLE;
  assign ins_ok    = idle & enq_buf_valid_q & ~pifo_busy & ~pifo_full;
  assign rem_ok    = idle & deq_pend_q & pifo_valid_out;
  assign grant_ins = ins_ok & (~rem_ok | last_grant_q == GR_REM);
  assign grant_rem = rem_ok & ~grant_ins;
  assign miss      = idle & deq_pend_q & ~rem_ok & occ_q == '0 & ~enq_buf_valid_q;
  assign enq_acc   = enq_valid & ~enq_buf_valid_q;
  assign deq_acc   = deq_req & ~deq_pend_q;

`ifdef PIFO_SCHED_DROP_EN
  logic [15:0] drop_q, drop_d;
  assign drop   = idle & enq_buf_valid_q & pifo_full;
  assign drop_d = drop & drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  // saturating count of enqueues discarded while the PIFO is full
  always_ff @(posedge clk) begin
    if (!rst) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_count = drop_q;
`else
  assign drop       = 1'b0;
  assign drop_count = '0;
`endif

  // next-state for the settle FSM, request buffers, arbitration history and result registers
  always_comb begin
    state_d         = idle ? (grant_ins | grant_rem ? SETTLE : IDLE) : (cnt_q == '0 ? IDLE : SETTLE);
    cnt_d           = idle ? (grant_ins | grant_rem ? SETTLE_LOAD : cnt_q) : (cnt_q == '0 ? cnt_q : cnt_q - 4'd1);
    enq_buf_valid_d = enq_acc | (enq_buf_valid_q & ~grant_ins & ~drop);
    enq_rank_d      = enq_acc ? enq_rank : enq_rank_q;
    enq_meta_d      = enq_acc ? enq_meta : enq_meta_q;
    deq_pend_d      = deq_acc | (deq_pend_q & ~grant_rem & ~miss);
    last_grant_d    = grant_ins ? GR_INS : grant_rem ? GR_REM : last_grant_q;
    occ_d           = grant_ins ? (occ_q == OCC_MAX ? occ_q : occ_q + OCC_ONE)
                    : grant_rem ? (occ_q == '0 ? occ_q : occ_q - OCC_ONE) : occ_q;
    deq_valid_d     = grant_rem;
    deq_rank_d      = grant_rem ? pifo_rank_out : deq_rank_q;
    deq_meta_d      = grant_rem ? pifo_meta_out : deq_meta_q;
    deq_miss_d      = miss;
  end

  // state registers; reset discards buffered requests and clears counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      enq_buf_valid_q <= 1'b0;
      enq_rank_q      <= '0;
      enq_meta_q      <= '0;
      deq_pend_q      <= 1'b0;
      last_grant_q    <= GR_REM;
      occ_q           <= '0;
      deq_valid_q     <= 1'b0;
      deq_rank_q      <= '0;
      deq_meta_q      <= '0;
      deq_miss_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      enq_buf_valid_q <= enq_buf_valid_d;
      enq_rank_q      <= enq_rank_d;
      enq_meta_q      <= enq_meta_d;
      deq_pend_q      <= deq_pend_d;
      last_grant_q    <= last_grant_d;
      occ_q           <= occ_d;
      deq_valid_q     <= deq_valid_d;
      deq_rank_q      <= deq_rank_d;
      deq_meta_q      <= deq_meta_d;
      deq_miss_q      <= deq_miss_d;
    end
  end

  // occupancy saturation would mean the PIFO and this counter disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(grant_ins && occ_q == OCC_MAX));
      assert (!(grant_rem && occ_q == '0));
    end
  end

  assign enq_ready    = ~enq_buf_valid_q;
  assign deq_ready    = ~deq_pend_q;
  assign deq_valid    = deq_valid_q;
  assign deq_rank     = deq_rank_q;
  assign deq_meta     = deq_meta_q;
  assign deq_miss     = deq_miss_q;
  assign pifo_insert  = grant_ins;
  assign pifo_remove  = grant_rem;
  assign pifo_rank_in = grant_ins ? enq_rank_q : '0;
  assign pifo_meta_in = grant_ins ? enq_meta_q : '0;
  assign occupancy    = occ_q;
endmodule

// File: tb/tb_pifo_sched_ctrl.sv
// tb_pifo_sched_ctrl: directed bench for pifo_sched_ctrl against a small sorted-list PIFO model
module tb_pifo_sched_ctrl;
  localparam int RW = 10;
  localparam int MW = 20;
  localparam int L2 = 5;
  localparam int SC = 2;

  logic clk = 0, rst = 0;
  logic enq_valid = 0, deq_req = 0, force_full = 0, force_busy = 0;
  logic [RW-1:0] enq_rank = '0;
  logic [MW-1:0] enq_meta = '0;
  logic enq_ready, deq_ready, deq_valid, deq_miss, pifo_insert, pifo_remove;
  logic [RW-1:0] deq_rank, pifo_rank_in, pifo_rank_out;
  logic [MW-1:0] deq_meta, pifo_meta_in, pifo_meta_out;
  logic pifo_valid_out, pifo_busy, pifo_full;
  logic [L2:0] occupancy;
  logic [15:0] drop_count;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, miss_n = 0;
  int st_cyc[$];
  bit st_ins[$];
  logic [RW-1:0] dq_rank[$];
  logic [MW-1:0] dq_meta[$];

  logic [RW+MW-1:0] m [0:31];
  int mcnt = 0;

  always #5 clk = ~clk;

  pifo_sched_ctrl #(.RANK_WIDTH(RW), .META_WIDTH(MW), .L2_MAX_SIZE(L2), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rank(enq_rank), .enq_meta(enq_meta),
    .deq_req(deq_req), .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_rank(deq_rank),
    .deq_meta(deq_meta), .deq_miss(deq_miss),
    .pifo_insert(pifo_insert), .pifo_remove(pifo_remove), .pifo_rank_in(pifo_rank_in),
    .pifo_meta_in(pifo_meta_in), .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
    .pifo_valid_out(pifo_valid_out), .pifo_busy(pifo_busy), .pifo_full(pifo_full),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  assign pifo_valid_out = mcnt > 0;
  assign pifo_rank_out  = mcnt > 0 ? m[0][RW+MW-1:MW] : '0;
  assign pifo_meta_out  = mcnt > 0 ? m[0][MW-1:0] : '0;
  assign pifo_full      = force_full | (mcnt == 32);
  assign pifo_busy      = force_busy;

  always @(posedge clk) begin : pifo_model
    logic [RW+MW-1:0] t [0:31];
    int n, p;
    t = m;
    n = mcnt;
    if (!rst) n = 0;
    else begin
      if (pifo_remove && n > 0) begin
        for (int i = 0; i < 31; i++) t[i] = t[i+1];
        n--;
      end
      if (pifo_insert && n < 32) begin
        p = n;
        while (p > 0 && t[p-1][RW+MW-1:MW] > pifo_rank_in) begin
          t[p] = t[p-1];
          p--;
        end
        t[p] = {pifo_rank_in, pifo_meta_in};
        n++;
      end
    end
    m <= t;
    mcnt <= n;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pifo_insert || pifo_remove) begin
      st_cyc.push_back(cyc);
      st_ins.push_back(pifo_insert);
    end
    if (deq_valid) begin
      dq_rank.push_back(deq_rank);
      dq_meta.push_back(deq_meta);
    end
    if (deq_miss) miss_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; enq_valid = 0; deq_req = 0; force_full = 0;
    step(); step();
    rst = 1;
  endtask

  task automatic enq(input logic [RW-1:0] r, input logic [MW-1:0] mt);
    int k = 0;
    while (!enq_ready && k < 60) begin step(); k++; end
    n_checks++;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL enq_wait: enq_ready=%b required 1", enq_ready); end
    enq_rank = r; enq_meta = mt; enq_valid = 1;
    step();
    enq_valid = 0;
  endtask

  task automatic deq();
    int k = 0;
    while (!deq_ready && k < 60) begin step(); k++; end
    n_checks++;
    if (deq_ready !== 1'b1) begin n_fail++; $display("FAIL deq_wait: deq_ready=%b required 1", deq_ready); end
    deq_req = 1;
    step();
    deq_req = 0;
  endtask

  task automatic wait_enq_ready();
    int k = 0;
    while (!enq_ready && k < 60) begin step(); k++; end
    n_checks++;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL enq_drain: enq_ready=%b required 1", enq_ready); end
  endtask

  task automatic wait_deq_count(input int target);
    int k = 0;
    while (dq_rank.size() < target && k < 120) begin step(); k++; end
    n_checks++;
    if (dq_rank.size() < target) begin n_fail++; $display("FAIL deq_results: got %0d required %0d", dq_rank.size(), target); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 10;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL rst_enq_ready: %b required 1", enq_ready); end
    if (deq_ready !== 1'b1) begin n_fail++; $display("FAIL rst_deq_ready: %b required 1", deq_ready); end
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_deq_valid: %b required 0", deq_valid); end
    if (deq_miss !== 1'b0) begin n_fail++; $display("FAIL rst_deq_miss: %b required 0", deq_miss); end
    if (pifo_insert !== 1'b0) begin n_fail++; $display("FAIL rst_insert: %b required 0", pifo_insert); end
    if (pifo_remove !== 1'b0) begin n_fail++; $display("FAIL rst_remove: %b required 0", pifo_remove); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL rst_occ: %0d required 0", occupancy); end
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop: %0d required 0", drop_count); end
    if (deq_rank !== '0) begin n_fail++; $display("FAIL rst_deq_rank: %0d required 0", deq_rank); end
    if (pifo_rank_in !== '0) begin n_fail++; $display("FAIL rst_rank_in: %0d required 0", pifo_rank_in); end
  endtask

  task automatic test_single_enq();
    enq_rank = 10'd7; enq_meta = 20'h00011; enq_valid = 1;
    step();
    enq_valid = 0;
    n_checks += 5;
    if (pifo_insert !== 1'b1) begin n_fail++; $display("FAIL single_insert: %b required 1", pifo_insert); end
    if (pifo_remove !== 1'b0) begin n_fail++; $display("FAIL single_no_remove: %b required 0", pifo_remove); end
    if (pifo_rank_in !== 10'd7) begin n_fail++; $display("FAIL single_rank_in: %0d required 7", pifo_rank_in); end
    if (pifo_meta_in !== 20'h00011) begin n_fail++; $display("FAIL single_meta_in: %h required 00011", pifo_meta_in); end
    if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL single_busy_ready: %b required 0", enq_ready); end
    step();
    n_checks += 4;
    if (pifo_insert !== 1'b0) begin n_fail++; $display("FAIL single_strobe_len: %b required 0", pifo_insert); end
    if (occupancy !== 6'd1) begin n_fail++; $display("FAIL single_occ: %0d required 1", occupancy); end
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: %b required 1", enq_ready); end
    if (pifo_rank_in !== '0) begin n_fail++; $display("FAIL single_rank_in_idle: %0d required 0", pifo_rank_in); end
    step(); step();
    deq_req = 1;
    step();
    deq_req = 0;
    n_checks += 2;
    if (pifo_remove !== 1'b1) begin n_fail++; $display("FAIL single_remove: %b required 1", pifo_remove); end
    if (deq_ready !== 1'b0) begin n_fail++; $display("FAIL single_deq_ready: %b required 0", deq_ready); end
    step();
    n_checks += 5;
    if (deq_valid !== 1'b1) begin n_fail++; $display("FAIL single_deq_valid: %b required 1", deq_valid); end
    if (deq_rank !== 10'd7) begin n_fail++; $display("FAIL single_deq_rank: %0d required 7", deq_rank); end
    if (deq_meta !== 20'h00011) begin n_fail++; $display("FAIL single_deq_meta: %h required 00011", deq_meta); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL single_occ_empty: %0d required 0", occupancy); end
    if (deq_ready !== 1'b1) begin n_fail++; $display("FAIL single_deq_ready_back: %b required 1", deq_ready); end
    step();
    n_checks += 2;
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL single_deq_pulse: %b required 0", deq_valid); end
    if (deq_rank !== 10'd7) begin n_fail++; $display("FAIL single_deq_hold: %0d required 7", deq_rank); end
  endtask

  task automatic test_order();
    int sb = st_cyc.size();
    int db = dq_rank.size();
    enq(10'd9, 20'h00090);
    enq(10'd3, 20'h00030);
    enq(10'd5, 20'h00050);
    wait_enq_ready();
    deq(); deq(); deq();
    wait_deq_count(db + 3);
    repeat (4) step();
    n_checks += 8;
    if (dq_rank.size() >= db + 3) begin
      if (dq_rank[db] !== 10'd3) begin n_fail++; $display("FAIL order_0: %0d required 3", dq_rank[db]); end
      if (dq_rank[db+1] !== 10'd5) begin n_fail++; $display("FAIL order_1: %0d required 5", dq_rank[db+1]); end
      if (dq_rank[db+2] !== 10'd9) begin n_fail++; $display("FAIL order_2: %0d required 9", dq_rank[db+2]); end
      if (dq_meta[db+2] !== 20'h00090) begin n_fail++; $display("FAIL order_meta: %h required 00090", dq_meta[db+2]); end
    end else begin
      n_fail += 4;
      $display("FAIL order_results: %0d results required 3", dq_rank.size() - db);
    end
    if (occupancy !== '0) begin n_fail++; $display("FAIL order_occ: %0d required 0", occupancy); end
    if (st_cyc.size() - sb !== 6) begin n_fail++; $display("FAIL order_strobes: %0d required 6", st_cyc.size() - sb); end
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL order_deq_idle: %b required 0", deq_valid); end
    if (deq_ready !== 1'b1) begin n_fail++; $display("FAIL order_deq_ready: %b required 1", deq_ready); end
    for (int i = sb + 1; i < st_cyc.size(); i++) begin
      n_checks++;
      if (st_cyc[i] - st_cyc[i-1] < SC + 1) begin
        n_fail++;
        $display("FAIL order_gap: %0d cycles required >= %0d", st_cyc[i] - st_cyc[i-1], SC + 1);
      end
    end
  endtask

  task automatic test_alternate();
    int sb, db, k;
    do_reset();
    for (int i = 1; i <= 5; i++) enq(10'(i * 10), 20'(i));
    wait_enq_ready();
    db = dq_rank.size();
    deq();
    wait_deq_count(db + 1);
    repeat (4) step();
    sb = st_cyc.size();
    db = dq_rank.size();
    enq_rank = 10'd60; enq_meta = 20'h00060; enq_valid = 1; deq_req = 1;
    k = 0;
    while (st_cyc.size() < sb + 4 && k < 60) begin step(); k++; end
    enq_valid = 0; deq_req = 0;
    step(); step();
    n_checks++;
    if (st_cyc.size() < sb + 4) begin
      n_fail++;
      $display("FAIL alt_strobes: %0d required 4", st_cyc.size() - sb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (st_ins[sb+i] !== ((i % 2) == 0)) begin
          n_fail++;
          $display("FAIL alt_order_%0d: insert=%b required %b", i, st_ins[sb+i], (i % 2) == 0);
        end
      end
    end
    n_checks++;
    if (dq_rank.size() < db + 2) begin
      n_fail++;
      $display("FAIL alt_results: %0d required 2", dq_rank.size() - db);
    end else begin
      n_checks++;
      if (dq_rank[db] !== 10'd20 || dq_rank[db+1] !== 10'd30) begin
        n_fail++;
        $display("FAIL alt_ranks: %0d,%0d required 20,30", dq_rank[db], dq_rank[db+1]);
      end
    end
  endtask

  task automatic test_miss();
    int sb, db, mb;
    do_reset();
    sb = st_cyc.size(); db = dq_rank.size(); mb = miss_n;
    deq_req = 1;
    step();
    deq_req = 0;
    step();
    n_checks++;
    if (deq_miss !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: %b required 1", deq_miss); end
    step();
    n_checks++;
    if (deq_miss !== 1'b0) begin n_fail++; $display("FAIL miss_single: %b required 0", deq_miss); end
    repeat (5) step();
    n_checks += 4;
    if (miss_n - mb !== 1) begin n_fail++; $display("FAIL miss_count: %0d required 1", miss_n - mb); end
    if (st_cyc.size() !== sb) begin n_fail++; $display("FAIL miss_no_remove: %0d strobes required 0", st_cyc.size() - sb); end
    if (dq_rank.size() !== db) begin n_fail++; $display("FAIL miss_no_valid: %0d results required 0", dq_rank.size() - db); end
    if (deq_ready !== 1'b1) begin n_fail++; $display("FAIL miss_ready: %b required 1", deq_ready); end
  endtask

  task automatic test_full();
    int sb;
    do_reset();
    sb = st_cyc.size();
    force_full = 1;
    enq(10'd8, 20'h00088);
`ifdef PIFO_SCHED_DROP_EN
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL drop_before: %0d required 0", drop_count); end
    step();
    n_checks += 4;
    if (drop_count !== 16'd1) begin n_fail++; $display("FAIL drop_count: %0d required 1", drop_count); end
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: %b required 1", enq_ready); end
    if (st_cyc.size() !== sb) begin n_fail++; $display("FAIL drop_no_strobe: %0d required 0", st_cyc.size() - sb); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL drop_occ: %0d required 0", occupancy); end
    force_full = 0;
`else
    repeat (8) step();
    n_checks += 4;
    if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_ready: %b required 0", enq_ready); end
    if (st_cyc.size() !== sb) begin n_fail++; $display("FAIL full_no_insert: %0d required 0", st_cyc.size() - sb); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL full_occ: %0d required 0", occupancy); end
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL full_drop_tied: %0d required 0", drop_count); end
    force_full = 0;
    #1;
    n_checks += 2;
    if (pifo_insert !== 1'b1) begin n_fail++; $display("FAIL full_release_insert: %b required 1", pifo_insert); end
    if (pifo_rank_in !== 10'd8) begin n_fail++; $display("FAIL full_release_rank: %0d required 8", pifo_rank_in); end
    step();
    n_checks += 2;
    if (occupancy !== 6'd1) begin n_fail++; $display("FAIL full_release_occ: %0d required 1", occupancy); end
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_release_ready: %b required 1", enq_ready); end
`endif
  endtask

  task automatic test_reset_mid();
    int sb, db, mb;
    do_reset();
    enq_rank = 10'd4; enq_meta = 20'h00004; enq_valid = 1;
    step();
    enq_valid = 0;
    n_checks++;
    if (pifo_insert !== 1'b1) begin n_fail++; $display("FAIL mid_insert: %b required 1", pifo_insert); end
    deq_req = 1;
    step();
    deq_req = 0;
    n_checks += 2;
    if (deq_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pend: %b required 0", deq_ready); end
    if (occupancy !== 6'd1) begin n_fail++; $display("FAIL mid_occ: %0d required 1", occupancy); end
    rst = 0;
    step();
    rst = 1;
    n_checks += 7;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL mid_enq_ready: %b required 1", enq_ready); end
    if (deq_ready !== 1'b1) begin n_fail++; $display("FAIL mid_deq_ready: %b required 1", deq_ready); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL mid_occ_clear: %0d required 0", occupancy); end
    if (pifo_insert !== 1'b0) begin n_fail++; $display("FAIL mid_insert_clear: %b required 0", pifo_insert); end
    if (pifo_remove !== 1'b0) begin n_fail++; $display("FAIL mid_remove_clear: %b required 0", pifo_remove); end
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_clear: %b required 0", deq_valid); end
    if (deq_miss !== 1'b0) begin n_fail++; $display("FAIL mid_miss_clear: %b required 0", deq_miss); end
    sb = st_cyc.size(); db = dq_rank.size(); mb = miss_n;
    repeat (10) step();
    n_checks += 3;
    if (st_cyc.size() !== sb) begin n_fail++; $display("FAIL mid_no_strobe: %0d required 0", st_cyc.size() - sb); end
    if (dq_rank.size() !== db) begin n_fail++; $display("FAIL mid_no_valid: %0d required 0", dq_rank.size() - db); end
    if (miss_n !== mb) begin n_fail++; $display("FAIL mid_no_miss: %0d required 0", miss_n - mb); end
  endtask

  initial begin
    test_reset();
    test_single_enq();
    test_order();
    test_alternate();
    test_miss();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pifo_sched_ctrl.md
Name: pifo_sched_ctrl

Overview:
- Front-end controller sitting between the packet pipeline and the PIFO top (parallel skip-list bank).
- Buffers one enqueue request and one dequeue request, and arbitrates them onto the PIFO's single insert/remove interface, alternating when both are eligible.
- Enforces a settle interval after every PIFO operation, registers dequeue results, and maintains occupancy and drop statistics.

Parameters:
- RANK_WIDTH, 10, rank width passed to the PIFO.
- META_WIDTH, 20, metadata width passed to the PIFO.
- L2_MAX_SIZE, 5, log2 of PIFO capacity; occupancy counter is L2_MAX_SIZE+1 bits.
- SETTLE_CYCLES, 2, idle cycles after each issued insert/remove before the next issue (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- enq_valid  in  1  enqueue request
- enq_ready  out  1  controller can accept an enqueue
- enq_rank  in  RANK_WIDTH  enqueue rank
- enq_meta  in  META_WIDTH  enqueue metadata
- deq_req  in  1  dequeue request (accepted when deq_ready=1)
- deq_ready  out  1  no dequeue outstanding
- deq_valid  out  1  one-cycle pulse, result valid
- deq_rank  out  RANK_WIDTH  dequeued rank
- deq_meta  out  META_WIDTH  dequeued metadata
- deq_miss  out  1  one-cycle pulse, dequeue discarded because PIFO empty
- pifo_insert  out  1  insert strobe to PIFO
- pifo_remove  out  1  remove strobe to PIFO
- pifo_rank_in  out  RANK_WIDTH  rank to PIFO
- pifo_meta_in  out  META_WIDTH  metadata to PIFO
- pifo_rank_out  in  RANK_WIDTH  PIFO head rank
- pifo_meta_out  in  META_WIDTH  PIFO head metadata
- pifo_valid_out  in  1  PIFO head valid
- pifo_busy  in  1  PIFO cannot insert
- pifo_full  in  1  PIFO full
- occupancy  out  L2_MAX_SIZE+1  entries currently held in the PIFO
- drop_count  out  16  saturating count of dropped enqueues

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, except enq_ready=1 and deq_ready=1; enq/deq buffers empty; state IDLE; settle counter 0; last_grant=REMOVE, so the first tie goes to insert.
- Enqueue buffer (1 entry):
  - enq_ready = ~enq_buf_valid.
  - enq_valid & enq_ready captures rank/meta at the edge.
  - Earliest pifo_insert is the following cycle.
- Dequeue buffer: deq_ready = ~deq_pend. deq_req & deq_ready sets deq_pend. deq_req while deq_pend=1 is ignored.
- Eligibility, evaluated in IDLE only:
  - ins_ok = enq_buf_valid & ~pifo_busy & ~pifo_full.
  - rem_ok = deq_pend & pifo_valid_out.
- Grant:
  - Only ins_ok: insert. Only rem_ok: remove.
  - Both: the opposite of last_grant; last_grant updates on every grant.
  - At most one of pifo_insert/pifo_remove is high in any cycle.
- Issue: the strobe is high for exactly one cycle.
  - pifo_rank_in/pifo_meta_in are driven from the buffer during the strobe and are 0 otherwise.
  - Insert clears enq_buf_valid; remove clears deq_pend.
- Dequeue result: on the remove cycle, pifo_rank_out/pifo_meta_out are registered; deq_valid=1 the next cycle only (latency 1). deq_rank/deq_meta hold until the next deq_valid.
- Empty: if deq_pend=1, occupancy=0, enq_buf_valid=0 and state is IDLE, clear deq_pend and pulse deq_miss next cycle.
- FSM:
  - IDLE to SETTLE on any grant, loading counter=SETTLE_CYCLES-1.
  - SETTLE decrements the counter and returns to IDLE when it reads 0.
  - No grants are made in SETTLE.
- occupancy: +1 on pifo_insert, -1 on pifo_remove; never both in the same cycle. Saturates at 2**L2_MAX_SIZE and at 0, which are assertion targets, not expected operation.
- Full without the optional feature: the enqueue waits in the buffer; backpressure appears through enq_ready.
- drop_count saturates at 16'hFFFF.
- Reset mid-operation: buffered requests are discarded, any strobe in flight is not reissued, and counters clear. The PIFO is reset on the same reset.

Optional Feature:
- Macro PIFO_SCHED_DROP_EN.
- Defined: while in IDLE, if enq_buf_valid & pifo_full, the buffered entry is dropped, enq_buf_valid clears and drop_count increments. No strobe is issued and no SETTLE is entered; dropping happens in the same cycle a remove may be granted.
- Undefined: no drops; drop_count is tied to 0; backpressure only.

Test Plan:
- Reset, then enqueue rank 7 / meta 0x00011 -> pifo_insert one cycle later with rank_in=7; occupancy=1; enq_ready high again after the insert.
- Enqueue ranks 9, 3, 5, then deq_req three times -> deq_valid pulses carry ranks 3, 5, 9; occupancy returns to 0; each consecutive PIFO strobe is at least SETTLE_CYCLES+1 cycles after the previous.
- Hold enq_valid and deq_req both eligible continuously, with the PIFO pre-filled to 4 -> strobes alternate insert, remove, insert, remove; the first tie goes to insert.
- deq_req with PIFO empty and no buffered enqueue -> deq_miss pulses once; no pifo_remove; deq_valid stays 0.
- Force pifo_full=1 with an enqueue pending:
  - Without the macro: enq_ready=0 is held and no insert occurs until pifo_full drops.
  - With PIFO_SCHED_DROP_EN: drop_count goes 0 to 1 and enq_ready returns to 1 the next cycle.
- Assert rst=0 while in SETTLE with deq_pend=1 -> next cycle all outputs are at reset values, occupancy=0, and no deq_valid or strobe follows.
